// File: rtl/prescaler_multi.sv
// Multi-channel prescaler: per-channel square wave, tick strobe and pending flag; outputs registered, one-edge latency.
// No backpressure: divisor writes are single-cycle strobes, applied at the channel's terminal count (or at once in HALT/sync).
module prescaler_multi #(
  parameter int          N_CH        = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 600000,
  parameter int          CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             sysclk,
  input  logic             i_rst,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic [N_CH-1:0]  o_clk,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q      [N_CH];
  logic [CNT_W-1:0] cnt_d      [N_CH];
  logic [CNT_W-1:0] div_act_q  [N_CH];
  logic [CNT_W-1:0] div_act_d  [N_CH];
  logic [CNT_W-1:0] div_pend_q [N_CH];
  logic [CNT_W-1:0] div_pend_d [N_CH];
  logic [CNT_W-1:0] nxt_div    [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  hit, tc, run;
  logic             wr_ok;

  // Out-of-range channel selects must not alias onto a real channel.
  assign wr_ok = i_wr_en && ({1'b0, i_wr_ch} < (CH_W+1)'(N_CH));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign hit[g]     = wr_ok && (i_wr_ch == CH_W'(g));
    assign run[g]     = (div_act_q[g] != '0);
    assign tc[g]      = run[g] && (cnt_q[g] == div_act_q[g] - CNT_W'(1));
    // Same-cycle write beats the older pending value.
    assign nxt_div[g] = hit[g] ? i_wr_div : (pend_q[g] ? div_pend_q[g] : div_act_q[g]);
  end

  always_comb begin
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c]      = cnt_q[c];
      div_act_d[c]  = div_act_q[c];
      div_pend_d[c] = div_pend_q[c];
      if (i_sync) begin
        cnt_d[c]     = '0;
        clk_d[c]     = 1'b0;
        div_act_d[c] = nxt_div[c];
        pend_d[c]    = 1'b0;
      end else if (!run[c]) begin
        cnt_d[c]  = '0;
        clk_d[c]  = 1'b0;
        pend_d[c] = 1'b0;
        if (hit[c]) div_act_d[c] = i_wr_div;
      end else if (tc[c]) begin
        cnt_d[c]     = '0;
        tick_d[c]    = 1'b1;
        div_act_d[c] = nxt_div[c];
        pend_d[c]    = 1'b0;
        clk_d[c]     = (nxt_div[c] == '0) ? 1'b0 : ~clk_q[c];
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        if (hit[c]) begin
          div_pend_d[c] = i_wr_div;
          pend_d[c]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]      <= '0;
        div_act_q[c]  <= DIV_RST;
        div_pend_q[c] <= '0;
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]      <= cnt_d[c];
        div_act_q[c]  <= div_act_d[c];
        div_pend_q[c] <= div_pend_d[c];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_pend = pend_q;

endmodule

// File: tb/tb_prescaler_multi.sv
// Directed bench for prescaler_multi: three channels, 8-bit counters, reset half-period of 4.
module tb_prescaler_multi;
  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             sysclk = 1'b0;
  logic             i_rst, i_sync, i_wr_en;
  logic [CH_W-1:0]  i_wr_ch;
  logic [CNT_W-1:0] i_wr_div;
  logic [N_CH-1:0]  o_clk, o_tick, o_pend;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  prescaler_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .sysclk  (sysclk),
    .i_rst   (i_rst),
    .i_sync  (i_sync),
    .i_wr_en (i_wr_en),
    .i_wr_ch (i_wr_ch),
    .i_wr_div(i_wr_div),
    .o_clk   (o_clk),
    .o_tick  (o_tick),
    .o_pend  (o_pend)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One edge, then check tick/clk/pend on the falling edge; single-cycle strobes are dropped.
  task automatic cyc(input logic [N_CH-1:0] t, input logic [N_CH-1:0] c, input logic [N_CH-1:0] p);
    @(posedge sysclk);
    @(negedge sysclk);
    cyc_no++;
    i_wr_en = 1'b0;
    i_sync  = 1'b0;
    chk($sformatf("tick@%0d", cyc_no), o_tick, t);
    chk($sformatf("clk@%0d", cyc_no), o_clk, c);
    chk($sformatf("pend@%0d", cyc_no), o_pend, p);
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] div);
    i_wr_en  = 1'b1;
    i_wr_ch  = ch;
    i_wr_div = div;
  endtask

  initial begin
    i_rst = 1'b1; i_sync = 1'b0; i_wr_en = 1'b0; i_wr_ch = '0; i_wr_div = '0;
    cyc(3'b000, 3'b000, 3'b000);
    cyc(3'b000, 3'b000, 3'b000);
    i_rst  = 1'b0;
    cyc_no = 0;

    // Reset default: H=4 on every channel
    for (int k = 1; k <= 12; k++)
      cyc((k % 4 == 0) ? 3'b111 : 3'b000, (((k / 4) % 2) == 1) ? 3'b111 : 3'b000, 3'b000);

    // Glitch-free update of ch0 to 2, written at cnt=1
    cyc(3'b000, 3'b111, 3'b000);              // 13
    wr(2'd0, 8'd2);
    cyc(3'b000, 3'b111, 3'b001);              // 14
    cyc(3'b000, 3'b111, 3'b001);              // 15
    cyc(3'b111, 3'b000, 3'b000);              // 16
    cyc(3'b000, 3'b000, 3'b000);              // 17
    cyc(3'b001, 3'b001, 3'b000);              // 18
    cyc(3'b000, 3'b001, 3'b000);              // 19
    cyc(3'b111, 3'b110, 3'b000);              // 20

    // Disable ch1, then re-enable it at H=3
    wr(2'd1, 8'd0);
    cyc(3'b000, 3'b110, 3'b010);              // 21
    cyc(3'b001, 3'b111, 3'b010);              // 22
    cyc(3'b000, 3'b111, 3'b010);              // 23
    cyc(3'b111, 3'b000, 3'b000);              // 24
    cyc(3'b000, 3'b000, 3'b000);              // 25
    cyc(3'b001, 3'b001, 3'b000);              // 26
    cyc(3'b000, 3'b001, 3'b000);              // 27
    cyc(3'b101, 3'b100, 3'b000);              // 28
    wr(2'd1, 8'd3);
    cyc(3'b000, 3'b100, 3'b000);              // 29
    cyc(3'b001, 3'b101, 3'b000);              // 30
    cyc(3'b000, 3'b101, 3'b000);              // 31
    cyc(3'b111, 3'b010, 3'b000);              // 32

    // Sync: ch2 pending 9 then 7, ch0 pending 3, ch1 written 5 with the sync
    wr(2'd2, 8'd9);
    cyc(3'b000, 3'b010, 3'b100);              // 33
    wr(2'd2, 8'd7);
    cyc(3'b001, 3'b011, 3'b100);              // 34
    wr(2'd0, 8'd3);
    cyc(3'b010, 3'b001, 3'b101);              // 35
    wr(2'd1, 8'd5);
    i_sync = 1'b1;
    cyc(3'b000, 3'b000, 3'b000);              // 36: sync wins over ch2 TC
    cyc(3'b000, 3'b000, 3'b000);              // 37
    cyc(3'b000, 3'b000, 3'b000);              // 38
    cyc(3'b001, 3'b001, 3'b000);              // 39
    cyc(3'b000, 3'b001, 3'b000);              // 40
    cyc(3'b010, 3'b011, 3'b000);              // 41
    cyc(3'b001, 3'b010, 3'b000);              // 42
    cyc(3'b100, 3'b110, 3'b000);              // 43

    // H=1 on ch0, write coincident with ch1 TC, invalid channel write
    wr(2'd0, 8'd1);
    cyc(3'b000, 3'b110, 3'b001);              // 44
    cyc(3'b001, 3'b111, 3'b000);              // 45
    wr(2'd1, 8'd2);
    cyc(3'b011, 3'b100, 3'b000);              // 46
    wr(2'd3, 8'd0);
    cyc(3'b001, 3'b101, 3'b000);              // 47
    cyc(3'b011, 3'b110, 3'b000);              // 48
    cyc(3'b001, 3'b111, 3'b000);              // 49
    cyc(3'b111, 3'b000, 3'b000);              // 50

    // Reset mid-count with ch2 write pending; pending value must be lost
    wr(2'd2, 8'd2);
    cyc(3'b001, 3'b001, 3'b100);              // 51
    i_rst = 1'b1;
    cyc(3'b000, 3'b000, 3'b000);              // 52
    i_rst = 1'b0;
    cyc(3'b000, 3'b000, 3'b000);              // 53
    cyc(3'b000, 3'b000, 3'b000);              // 54
    cyc(3'b000, 3'b000, 3'b000);              // 55
    cyc(3'b111, 3'b111, 3'b000);              // 56
    cyc(3'b000, 3'b111, 3'b000);              // 57
    cyc(3'b000, 3'b111, 3'b000);              // 58

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/prescaler_multi.md
# prescaler_multi

Parametrised multi-channel clock prescaler. It derives N_CH independent low-rate square-wave enables and single-cycle tick strobes from sysclk. Each channel's divisor is programmable at run time, and updates take effect glitch-free at the channel's terminal count. It replaces fixed-rate prescalers in the design: 10 Hz, display scan and debounce rates all come from one instance. A common sync input re-phases all channels together.

## Interface
- N_CH, default 4: number of independent channels.
- CNT_W, default 32: counter and divisor width.
- DEFAULT_DIV, default 600000: half-period in sysclk cycles, loaded into every channel at reset. Must be < 2^CNT_W.
- CH_W, default max(1, clog2(N_CH)): channel-select width. Derived; do not override.

Ports:
- sysclk  in  1: system clock. All logic is on its rising edge.
- i_rst  in  1: **one clock; reset is synchronous and active-high.**
- i_sync  in  1: restart all channels in phase.
- i_wr_en  in  1: divisor write strobe, one cycle per write.
- i_wr_ch  in  CH_W: target channel of the write.
- i_wr_div  in  CNT_W: new half-period H. 0 disables the channel.
- o_clk  out  N_CH: per-channel square wave, period 2H.
- o_tick  out  N_CH: per-channel one-cycle strobe, once every H cycles.
- o_pend  out  N_CH: per-channel flag; a written divisor is waiting for the terminal count.

## Operation
Per-channel state:
- cnt[CNT_W]
- div_act[CNT_W]
- div_pend[CNT_W]
- pend_v

All outputs are registered.

Reset (i_rst=1 at an edge), which overrides everything:
- cnt=0, div_act=DEFAULT_DIV, pend_v=0.
- o_clk=0, o_tick=0, o_pend=0.

States per channel: RUN (div_act≠0) and HALT (div_act=0).

RUN, each edge:
- If cnt==div_act-1 (terminal count, TC): cnt←0, o_tick←1, o_clk←~o_clk.
  - The new div_act is chosen in this priority: a same-cycle write to this channel, else div_pend if pend_v, else unchanged. pend_v←0.
  - If the new div_act is 0, o_clk←0 instead of toggling, and the channel enters HALT.
- Otherwise: cnt←cnt+1, o_tick←0.

HALT:
- cnt=0, o_clk=0, o_tick=0.
- A write to the channel loads div_act directly at the next edge, with pend_v staying 0. The channel then runs from cnt=0.

Writes:
- i_wr_en=1 with i_wr_ch<N_CH, channel in RUN and not at TC: div_pend←i_wr_div, pend_v←1.
- A second write before TC overwrites div_pend; last write wins.
- i_wr_ch≥N_CH: the write is ignored.

Sync (i_sync=1, i_rst=0), applied to all channels:
- cnt←0, o_clk←0, o_tick←0.
- The pending divisor, if any, is applied immediately, and pend_v←0.
- A write in the same cycle is applied directly to div_act and takes priority over the old pending value.
- Sync has priority over TC.

o_pend mirrors pend_v.

Arithmetic:
- cnt compares against div_act-1 computed in CNT_W bits. div_act=0 never reaches the comparator because the channel is in HALT.
- H=1 gives o_tick high continuously and o_clk = sysclk/2.

## Timing
- After reset is released, or after a sync edge, with H≠0: o_tick is high in the cycle after edge number H. o_clk first rises at that same edge.
- Steady state:
  - o_tick period is H cycles, high for 1 cycle.
  - o_clk is high for H cycles, then low for H cycles. The duty cycle is exactly 50%.
- Divisor update latency:
  - The new value takes effect at the first TC after the write. The current half-period always completes at the old H.
  - o_pend rises the edge after the write and falls at that TC.
- A write in HALT takes effect at the next edge. The first tick follows H cycles after that edge.
- Reset mid-count is immediate at the next edge. Any pending write is discarded.

## Test plan
- **Reset default.** DEFAULT_DIV=4, release i_rst. Required: o_tick pulses in cycles 4, 8, 12…; o_clk is 0 for cycles 0–3, 1 for cycles 4–7, and so on; o_pend=0.
- **Glitch-free update.** H=4 running. Write ch0=2 at mid-count (cnt=1). Required:
  - o_pend[0]=1 until the next TC.
  - The current half-period still lasts 4 cycles, then ticks come every 2 cycles.
  - Other channels are unaffected.
- **Disable and re-enable.** Write ch1=0. Required: at the next TC ch1 ticks once, o_clk[1]=0, and the channel stays silent. Then write ch1=3: a tick follows 3 cycles after the write is applied.
- **Sync alignment.** Channels at H=3, 5 and 7 with arbitrary phase. Pulse i_sync. Required:
  - All o_clk=0 and all cnt=0 after the sync edge.
  - The first ticks come 3, 5 and 7 cycles later.
  - A pending write on ch2 is applied at the sync edge.
- **Boundary and collisions.**
  - H=1: o_tick is high every cycle.
  - A write coincident with TC applies the new value at that TC, and o_pend stays 0.
  - i_wr_ch=N_CH (when N_CH<2^CH_W) changes nothing.
  - i_rst asserted mid-count with a write pending: all outputs 0 next cycle, and the pending value is discarded.
